// File: rtl/cv32e40p_register_file_sb.sv
// Multi-ported register file with a per-register reservation scoreboard.
// Long-latency destinations are reserved up front and released by a clearing write.
module cv32e40p_register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3,
  parameter int NUM_WPORTS = 2,
  parameter int FP_REGS    = 0,
  parameter int BYPASS     = 1,
  localparam int AW        = 5 + FP_REGS,
  localparam int NUM_REGS  = 32 * (1 + FP_REGS),
  localparam int CW        = $clog2(NUM_REGS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_RPORTS-1:0][AW-1:0]         raddr_i,
  output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]                 rbusy_o,
  input  logic [NUM_WPORTS-1:0]                 we_i,
  input  logic [NUM_WPORTS-1:0][AW-1:0]         waddr_i,
  input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WPORTS-1:0]                 wclr_i,
  input  logic                                 rsv_valid_i,
  input  logic [AW-1:0]                        rsv_addr_i,
  output logic                                 rsv_ready_o,
  output logic [CW-1:0]                        busy_cnt_o,
  output logic                                 err_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CW-1:0]         busy_cnt_q, busy_cnt_d;
  logic                  err_q, err_d;
  logic [NUM_REGS-1:0]   clr_vec;
  logic [NUM_REGS-1:0]   set_vec;
  logic                  rsv_accept;

  // Registers whose reservation is retired by a clearing write this cycle.
  always_comb begin
    clr_vec = '0;
    for (int w = 0; w < NUM_WPORTS; w++) begin
      if (we_i[w] && wclr_i[w]) clr_vec[waddr_i[w]] = 1'b1;
    end
    clr_vec[0] = 1'b0;
  end

  assign rsv_ready_o = ~busy_q[rsv_addr_i] | clr_vec[rsv_addr_i];
  assign rsv_accept  = rsv_valid_i & rsv_ready_o & (rsv_addr_i != '0);

  always_comb begin
    set_vec = '0;
    if (rsv_accept) set_vec[rsv_addr_i] = 1'b1;
  end

  // A reservation landing on a register being cleared keeps it busy.
  assign busy_d = (busy_q & ~clr_vec) | set_vec;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (busy_d[r] && !busy_q[r]) begin
        busy_cnt_d = busy_cnt_d + CW'(1);
      end else if (!busy_d[r] && busy_q[r]) begin
        busy_cnt_d = busy_cnt_d - CW'(1);
      end
    end
  end

  always_comb begin
    err_d = 1'b0;
    for (int w = 0; w < NUM_WPORTS; w++) begin
      if (we_i[w] && wclr_i[w] && waddr_i[w] != '0 && !busy_q[waddr_i[w]]) err_d = 1'b1;
    end
  end

  // Later write ports override earlier ones on an address collision.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      mem_d[r] = mem_q[r];
      for (int w = 0; w < NUM_WPORTS; w++) begin
        if (we_i[w] && waddr_i[w] == AW'(r) && r != 0) mem_d[r] = wdata_i[w];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rdata_o[p] = mem_q[raddr_i[p]];
      rbusy_o[p] = busy_q[raddr_i[p]];
      if (BYPASS != 0 && raddr_i[p] != '0) begin
        for (int w = 0; w < NUM_WPORTS; w++) begin
          if (we_i[w] && waddr_i[w] == raddr_i[p]) rdata_o[p] = wdata_i[w];
        end
        if (clr_vec[raddr_i[p]]) rbusy_o[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= mem_d[r];
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      err_q      <= err_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_cv32e40p_register_file_sb.sv
// Randomised and directed check of the scoreboarded register file against a
// behavioural model evaluated every falling clock edge.
module tb_cv32e40p_register_file_sb;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0][4:0] raddr_i = '0;
  logic [2:0][31:0] rdata_o;
  logic [2:0]      rbusy_o;
  logic [1:0]      we_i = '0;
  logic [1:0][4:0] waddr_i = '0;
  logic [1:0][31:0] wdata_i = '0;
  logic [1:0]      wclr_i = '0;
  logic            rsv_valid_i = 1'b0;
  logic [4:0]      rsv_addr_i = '0;
  logic            rsv_ready_o;
  logic [5:0]      busy_cnt_o;
  logic            err_o;

  int checks = 0;
  int errors = 0;

  bit [31:0] m_regs [32];
  bit        m_busy [32];
  bit        m_err;

  cv32e40p_register_file_sb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raddr_i     (raddr_i),
    .rdata_o     (rdata_o),
    .rbusy_o     (rbusy_o),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .wclr_i      (wclr_i),
    .rsv_valid_i (rsv_valid_i),
    .rsv_addr_i  (rsv_addr_i),
    .rsv_ready_o (rsv_ready_o),
    .busy_cnt_o  (busy_cnt_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit clr_hit(input int a);
    for (int w = 0; w < 2; w++)
      if (we_i[w] && wclr_i[w] && int'(waddr_i[w]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [31:0] exp_rdata(input int a);
    bit [31:0] v;
    v = m_regs[a];
    if (a != 0)
      for (int w = 0; w < 2; w++)
        if (we_i[w] && int'(waddr_i[w]) == a) v = wdata_i[w];
    return v;
  endfunction

  function automatic bit exp_ready();
    return !m_busy[int'(rsv_addr_i)] || clr_hit(int'(rsv_addr_i));
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  // Reference model: architectural state advanced once per edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      bit old_busy [32];
      bit acc;
      old_busy = m_busy;
      acc = rsv_valid_i && exp_ready() && rsv_addr_i != 0;
      m_err = 1'b0;
      for (int w = 0; w < 2; w++) begin
        if (we_i[w] && wclr_i[w]) begin
          if (waddr_i[w] != 0 && !old_busy[int'(waddr_i[w])]) m_err = 1'b1;
          m_busy[int'(waddr_i[w])] = 1'b0;
        end
      end
      if (acc) m_busy[int'(rsv_addr_i)] = 1'b1;
      for (int w = 0; w < 2; w++)
        if (we_i[w] && waddr_i[w] != 0) m_regs[int'(waddr_i[w])] = wdata_i[w];
    end
  end

  always @(negedge clk) begin
    check("rsv_ready", 32'(rsv_ready_o), 32'(exp_ready()));
    check("busy_cnt", 32'(busy_cnt_o), 32'(exp_cnt()));
    check("err", 32'(err_o), 32'(m_err));
    for (int p = 0; p < 3; p++) begin
      int a;
      a = int'(raddr_i[p]);
      check("rdata", rdata_o[p], exp_rdata(a));
      check("rbusy", 32'(rbusy_o[p]), 32'(m_busy[a] && !clr_hit(a)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = '0;
    wclr_i = '0;
    rsv_valid_i = 1'b0;
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d, input logic clr);
    we_i[port] = 1'b1;
    waddr_i[port] = a;
    wdata_i[port] = d;
    wclr_i[port] = clr;
  endtask

  initial begin
    tick(); tick();
    #2;
    check("reset_ready", 32'(rsv_ready_o), 32'd1);
    check("reset_cnt", 32'(busy_cnt_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    tick();
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      raddr_i[0] = 5'(a);
      raddr_i[1] = 5'(31 - a);
      raddr_i[2] = 5'(a);
      #2 check("rd_after_reset", rdata_o[0], 32'd0);
      tick();
    end

    wr(0, 5'd5, 32'hDEADBEEF, 1'b0);
    raddr_i[1] = 5'd5;
    #2 check("bypass_x5", rdata_o[1], 32'hDEADBEEF);
    tick(); idle();
    raddr_i[0] = 5'd5;
    #2 check("read_x5", rdata_o[0], 32'hDEADBEEF);
    wr(0, 5'd0, 32'h1234, 1'b0);
    raddr_i[0] = 5'd0;
    #2 check("x0_same_cycle", rdata_o[0], 32'd0);
    tick(); idle();
    #2 check("x0_after", rdata_o[0], 32'd0);

    wr(0, 5'd7, 32'hA, 1'b0);
    wr(1, 5'd7, 32'hB, 1'b0);
    raddr_i[2] = 5'd7;
    #2 check("x7_bypass_hi", rdata_o[2], 32'hB);
    tick(); idle();
    #2 check("x7_stored_hi", rdata_o[2], 32'hB);

    rsv_valid_i = 1'b1; rsv_addr_i = 5'd9;
    #2 check("rsv9_ready", 32'(rsv_ready_o), 32'd1);
    tick();
    raddr_i[0] = 5'd9;
    #2;
    check("rbusy9", 32'(rbusy_o[0]), 32'd1);
    check("cnt_one", 32'(busy_cnt_o), 32'd1);
    check("rsv9_again", 32'(rsv_ready_o), 32'd0);
    tick(); idle();
    wr(0, 5'd9, 32'h99, 1'b1);
    #2 check("rbusy9_masked", 32'(rbusy_o[0]), 32'd0);
    tick(); idle();
    #2;
    check("cnt_cleared", 32'(busy_cnt_o), 32'd0);
    check("no_err_clr", 32'(err_o), 32'd0);

    rsv_valid_i = 1'b1; rsv_addr_i = 5'd9;
    tick();
    wr(0, 5'd9, 32'h55, 1'b1);
    #2 check("rerserve_ready", 32'(rsv_ready_o), 32'd1);
    tick(); idle();
    #2;
    check("cnt_kept", 32'(busy_cnt_o), 32'd1);
    check("rbusy9_kept", 32'(rbusy_o[0]), 32'd1);
    check("x9_written", rdata_o[0], 32'h55);
    check("no_err_rersv", 32'(err_o), 32'd0);
    wr(1, 5'd9, 32'h0, 1'b1);
    tick(); idle();

    wr(0, 5'd3, 32'h33, 1'b1);
    tick(); idle();
    raddr_i[0] = 5'd3;
    #2;
    check("err_pulse", 32'(err_o), 32'd1);
    check("x3_written", rdata_o[0], 32'h33);
    tick();
    #2 check("err_one_cycle", 32'(err_o), 32'd0);
    rsv_valid_i = 1'b1; rsv_addr_i = 5'd0;
    #2 check("rsv0_ready", 32'(rsv_ready_o), 32'd1);
    tick(); idle();
    #2 check("rsv0_cnt", 32'(busy_cnt_o), 32'd0);

    for (int r = 4; r < 7; r++) begin
      rsv_valid_i = 1'b1; rsv_addr_i = 5'(r);
      tick();
    end
    idle();
    raddr_i[0] = 5'd4; raddr_i[1] = 5'd5; raddr_i[2] = 5'd6;
    #1 check("cnt_three", 32'(busy_cnt_o), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_cnt", 32'(busy_cnt_o), 32'd0);
    check("rst_rbusy", 32'(rbusy_o), 32'd0);
    check("rst_ready", 32'(rsv_ready_o), 32'd1);
    tick();
    rst_n = 1'b1;
    wr(0, 5'd4, 32'h44, 1'b1);
    tick(); idle();
    #2 check("err_after_rst", 32'(err_o), 32'd1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 3; p++) raddr_i[p] = 5'($urandom_range(0, 15));
      for (int w = 0; w < 2; w++) begin
        we_i[w]    = 1'($urandom_range(0, 1));
        waddr_i[w] = 5'($urandom_range(0, 15));
        wdata_i[w] = $urandom;
        wclr_i[w]  = ($urandom_range(0, 2) == 0);
      end
      rsv_valid_i = 1'($urandom_range(0, 1));
      rsv_addr_i  = 5'($urandom_range(0, 15));
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
